// File: rtl/axi_ldst_pkg.sv
// axi_ldst_pkg: shared types and constants for the buffered load/store AXI master
package axi_ldst_pkg;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: circular store queue with a parallel word-address match over live entries
module store_buffer_fifo
    import axi_ldst_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  sb_entry_t                 push_entry,
    input  logic                      pop,
    input  logic [SB_ADDR_W-1:0]      match_addr,
    output sb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      hit
);
    localparam int PW = $clog2(DEPTH);
    sb_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DEPTH-1:0] match;
    logic unused_lsb;
    assign unused_lsb = ^match_addr[1:0];
    assign head = mem[rd_ptr];
    assign hit = |match;
    // Entry storage is not reset; only the live window between the pointers is meaningful
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end
    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] ofs;
        assign ofs = PW'(i) - rd_ptr;
        assign match[i] = ({1'b0, ofs} < count) && (mem[i].addr[SB_ADDR_W-1:2] == match_addr[SB_ADDR_W-1:2]);
    end
endmodule

// File: rtl/axi_ldst_buffered_master.sv
// axi_ldst_buffered_master: AXI4 data master with posted store buffer and load-after-store hazard check
module axi_ldst_buffered_master
    import axi_ldst_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int ID_W = 4,
    parameter int MASTER_ID = 1,
    parameter int SB_DEPTH = 4,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_data_valid,
    output logic [DATA_W-1:0] ld_data,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    input  logic [STRB_W-1:0] st_req_strb,
    output logic              sb_empty,
    output logic              wr_err,
    output logic              rd_err,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);
    localparam int CW = $clog2(SB_DEPTH) + 1;
    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;
    logic [CW-1:0] sb_count;
    sb_entry_t sb_head;
    logic sb_hit, push, pop, aw_done, w_done, aw_hs, w_hs, st_hit, ld_hs;
    logic unused_ok;
    assign unused_ok = ^{BID, BRESP[0], RID, RRESP[0], RLAST};
    assign AWID = ID_W'(MASTER_ID);
    assign ARID = ID_W'(MASTER_ID);
    assign AWLEN = 4'd0;
    assign ARLEN = 4'd0;
    assign AWSIZE = 3'($clog2(STRB_W));
    assign ARSIZE = 3'($clog2(STRB_W));
    assign AWBURST = AXI_BURST_INCR;
    assign ARBURST = AXI_BURST_INCR;
    assign WLAST = WVALID;
    assign st_req_ready = (sb_count != CW'(SB_DEPTH));
    assign push = st_req_valid && st_req_ready;
    assign pop = BVALID && BREADY;
    assign sb_empty = (sb_count == '0) && (w_state == W_IDLE);
    store_buffer_fifo #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{addr: st_req_addr, data: st_req_data, strb: st_req_strb}),
        .pop        (pop),
        .match_addr (ld_req_addr),
        .head       (sb_head),
        .count      (sb_count),
        .hit        (sb_hit)
    );
    // Write engine: AW and W complete independently, then wait for the single B
    always_comb begin
        AWVALID = (w_state == W_SEND) && !aw_done;
        WVALID  = (w_state == W_SEND) && !w_done;
        BREADY  = (w_state == W_RESP);
        aw_hs   = AWVALID && AWREADY;
        w_hs    = WVALID && WREADY;
        w_next  = (w_state == W_IDLE && sb_count != '0) ? W_SEND :
                  (w_state == W_SEND && (aw_done || aw_hs) && (w_done || w_hs)) ? W_RESP :
                  (w_state == W_RESP && BVALID) ? W_IDLE : w_state;
    end
    // Write payload is captured from the buffer head when a transfer starts and held until B
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wr_err  <= 1'b0;
            AWADDR  <= '0;
            WDATA   <= '0;
            WSTRB   <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && w_next == W_SEND) begin
                AWADDR  <= sb_head.addr;
                WDATA   <= sb_head.data;
                WSTRB   <= sb_head.strb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs) w_done <= 1'b1;
            end
            if (pop && BRESP[1]) wr_err <= 1'b1;
        end
    end
    // Read engine: a load may not pass any buffered or same-cycle store to the same word
    always_comb begin
        st_hit        = st_req_valid && (st_req_addr[ADDR_W-1:2] == ld_req_addr[ADDR_W-1:2]);
        ld_req_ready  = (r_state == R_IDLE) && !sb_hit && !st_hit;
        ld_hs         = ld_req_valid && ld_req_ready;
        ARVALID       = (r_state == R_ADDR);
        RREADY        = (r_state == R_DATA);
        ld_data_valid = RREADY && RVALID;
        ld_data       = ld_data_valid ? RDATA : '0;
        rd_err        = ld_data_valid && RRESP[1];
        r_next        = (r_state == R_IDLE && ld_hs) ? R_ADDR :
                        (r_state == R_ADDR && ARREADY) ? R_DATA :
                        (r_state == R_DATA && RVALID) ? R_IDLE : r_state;
    end
    // Read state and registered load address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            ARADDR  <= '0;
        end else begin
            r_state <= r_next;
            if (ld_hs) ARADDR <= ld_req_addr;
        end
    end
endmodule
